// File: rtl/wavetable_osc.sv
// rtl/wavetable_osc.sv - Wavetable oscillator with linear interpolation, one sample per pblrc fall.
module wavetable_osc #(
    parameter int SAMPLE_BITS = 16,
    parameter int ADDR_BITS   = 8,
    parameter int PHASE_BITS  = 32,
    parameter int FRAC_BITS   = 8
) (
    input  logic                   mclk,
    input  logic                   rst_n,
    input  logic                   pblrc,
    input  logic [PHASE_BITS-1:0]  freq_word,
    input  logic                   tbl_we,
    input  logic [ADDR_BITS-1:0]   tbl_waddr,
    input  logic [SAMPLE_BITS-1:0] tbl_wdata,
    output logic [SAMPLE_BITS-1:0] sample_out,
    output logic                   sample_valid,
    output logic                   busy,
    output logic                   overrun
);

    localparam int PW = SAMPLE_BITS + FRAC_BITS + 2;

    typedef enum logic [2:0] {IDLE, RD0, RD1, MAC, OUT} state_e;

    state_e                 state_q, state_d;
    logic                   sync1_q, sync2_q, sync3_q;
    logic                   req;
    logic [PHASE_BITS-1:0]  phase_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [FRAC_BITS-1:0]   frac_q;
    logic [SAMPLE_BITS-1:0] s0_q;
    logic [SAMPLE_BITS-1:0] sample_q;
    logic                   valid_q;
    logic                   overrun_q;

    logic [SAMPLE_BITS-1:0] mem [2**ADDR_BITS];
    logic [ADDR_BITS-1:0]   raddr;
    logic [SAMPLE_BITS-1:0] rdata_q;

    logic signed [SAMPLE_BITS:0] diff;
    logic signed [PW-1:0]        diff_ext, frac_ext, prod, s0_ext, sum;
    logic [SAMPLE_BITS-1:0]      sample_d;
    logic                        unused_sum_bits;

    assign req = sync3_q & ~sync2_q;

    always_comb begin
        state_d = state_q;
        raddr   = idx_q;
        case (state_q)
            IDLE: if (req) state_d = RD0;
            RD0:  state_d = RD1;
            RD1: begin
                raddr   = idx_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
                state_d = MAC;
            end
            MAC:  state_d = OUT;
            OUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Table RAM: the read sees pre-write contents on a same-address collision.
    always_ff @(posedge mclk) begin
        if (tbl_we) mem[tbl_waddr] <= tbl_wdata;
        rdata_q <= mem[raddr];
    end

    // In MAC, rdata_q holds the upper neighbour s1.
    always_comb begin
        diff     = $signed({rdata_q[SAMPLE_BITS-1], rdata_q}) - $signed({s0_q[SAMPLE_BITS-1], s0_q});
        diff_ext = {{(PW-SAMPLE_BITS-1){diff[SAMPLE_BITS]}}, diff};
        frac_ext = {{(PW-FRAC_BITS){1'b0}}, frac_q};
        prod     = diff_ext * frac_ext;
        s0_ext   = {{(PW-SAMPLE_BITS){s0_q[SAMPLE_BITS-1]}}, s0_q};
        sum      = s0_ext + (prod >>> FRAC_BITS);
        sample_d = sum[SAMPLE_BITS-1:0];
    end

    assign unused_sum_bits = ^sum[PW-1:SAMPLE_BITS];

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            phase_q   <= '0;
            idx_q     <= '0;
            frac_q    <= '0;
            s0_q      <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= pblrc;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            valid_q <= (state_q == MAC);
            if (state_q == IDLE && req) begin
                idx_q  <= phase_q[PHASE_BITS-1 -: ADDR_BITS];
                frac_q <= phase_q[PHASE_BITS-ADDR_BITS-1 -: FRAC_BITS];
            end
            if (state_q != IDLE && req) overrun_q <= 1'b1;
            if (state_q == RD1) s0_q <= rdata_q;
            // Result is registered on MAC->OUT so it is visible while valid is high in OUT.
            if (state_q == MAC) sample_q <= sample_d;
            if (state_q == OUT) phase_q <= phase_q + freq_word;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;

endmodule
